// File: rtl/rv32_alu_decode_stage.sv
// -----------------------------------------------------------------------------
// rv32_alu_decode_stage
//   Registered RV32I decode stage. It accepts an instruction and its PC over a
//   valid/ready handshake and decodes them into the ALU control bundle: alu_op,
//   funct3, funct7_bit5, operand selects, immediate, register indices and
//   side-effect enables. The bundle is held in a one-entry pipeline register and
//   presented to execute one cycle later over a second valid/ready handshake.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   flush                 drops the held bundle and the incoming instruction
//   in_valid/in_ready     fetch-side handshake; in_instr, in_pc carry the payload
//   out_valid/out_ready   execute-side handshake
//   alu_op, funct3, funct7_bit5, a_sel, b_sel, imm, pc_out, rs1, rs2, rd,
//   reg_write, mem_read, mem_write, branch, jump, illegal   registered bundle
// -----------------------------------------------------------------------------
module rv32_alu_decode_stage #(
  parameter int unsigned XLEN           = 32,
  parameter bit          ILLEGAL_AS_NOP = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic [2:0]      funct3,
  output logic            funct7_bit5,
  output logic [1:0]      a_sel,
  output logic [1:0]      b_sel,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            jump,
  output logic            illegal
);

  localparam int unsigned ALU_W = 4;
  localparam int unsigned REG_W = 5;
  localparam int unsigned SEL_W = 2;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_SLT  = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_SLTU = 4'b0011;

  localparam logic [SEL_W-1:0] A_RS1  = 2'b00;
  localparam logic [SEL_W-1:0] A_PC   = 2'b01;
  localparam logic [SEL_W-1:0] A_ZERO = 2'b10;
  localparam logic [SEL_W-1:0] B_RS2  = 2'b00;
  localparam logic [SEL_W-1:0] B_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] B_FOUR = 2'b10;

  typedef struct packed {
    logic [ALU_W-1:0] alu_op;
    logic [2:0]       funct3;
    logic             funct7_bit5;
    logic [SEL_W-1:0] a_sel;
    logic [SEL_W-1:0] b_sel;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             branch;
    logic             jump;
    logic             illegal;
  } bundle_t;

  // Instruction fields
  logic [6:0]       opcode;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [REG_W-1:0] rs1_f;
  logic [REG_W-1:0] rs2_f;
  logic [REG_W-1:0] rd_f;

  assign opcode = in_instr[6:0];
  assign rd_f   = in_instr[11:7];
  assign f3     = in_instr[14:12];
  assign rs1_f  = in_instr[19:15];
  assign rs2_f  = in_instr[24:20];
  assign f7     = in_instr[31:25];

  // Sign-extended immediates for each format; shift amounts are zero-extended
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
  assign imm_sh = XLEN'(in_instr[24:20]);

  bundle_t dec_d;
  bundle_t bundle_q;
  logic    instr_bad;
  logic    out_valid_d;
  logic    out_valid_q;
  logic    capture;

  // Combinational decode of the incoming instruction
  always_comb begin
    dec_d        = '0;
    instr_bad    = 1'b0;
    dec_d.funct3 = f3;
    dec_d.pc     = in_pc;

    case (opcode)
      OPC_OP: begin
        dec_d.a_sel       = A_RS1;
        dec_d.b_sel       = B_RS2;
        dec_d.rs1         = rs1_f;
        dec_d.rs2         = rs2_f;
        dec_d.rd          = rd_f;
        dec_d.reg_write   = 1'b1;
        dec_d.alu_op      = {1'b0, f3};
        dec_d.funct7_bit5 = in_instr[30];
        // Only SUB and SRA may use the alternate funct7
        if (!((f7 == F7_BASE) ||
              ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))))) begin
          instr_bad = 1'b1;
        end
      end

      OPC_OP_IMM: begin
        dec_d.a_sel     = A_RS1;
        dec_d.b_sel     = B_IMM;
        dec_d.rs1       = rs1_f;
        dec_d.rd        = rd_f;
        dec_d.reg_write = 1'b1;
        dec_d.alu_op    = {1'b0, f3};
        dec_d.imm       = imm_i;
        if (f3 == 3'b001) begin
          dec_d.imm = imm_sh;
          if (f7 != F7_BASE) instr_bad = 1'b1;
        end else if (f3 == 3'b101) begin
          dec_d.imm         = imm_sh;
          dec_d.funct7_bit5 = in_instr[30];
          if ((f7 != F7_BASE) && (f7 != F7_ALT)) instr_bad = 1'b1;
        end
      end

      OPC_LOAD: begin
        dec_d.a_sel     = A_RS1;
        dec_d.b_sel     = B_IMM;
        dec_d.imm       = imm_i;
        dec_d.rs1       = rs1_f;
        dec_d.rd        = rd_f;
        dec_d.alu_op    = ALU_ADD;
        dec_d.mem_read  = 1'b1;
        dec_d.reg_write = 1'b1;
      end

      OPC_STORE: begin
        dec_d.a_sel     = A_RS1;
        dec_d.b_sel     = B_IMM;
        dec_d.imm       = imm_s;
        dec_d.rs1       = rs1_f;
        dec_d.rs2       = rs2_f;
        dec_d.alu_op    = ALU_ADD;
        dec_d.mem_write = 1'b1;
      end

      OPC_BRANCH: begin
        dec_d.a_sel  = A_RS1;
        dec_d.b_sel  = B_RS2;
        dec_d.imm    = imm_b;
        dec_d.rs1    = rs1_f;
        dec_d.rs2    = rs2_f;
        dec_d.branch = 1'b1;
        // Equality compares via subtract; ordering compares via SLT/SLTU
        case (f3[2:1])
          2'b00: begin
            dec_d.alu_op      = ALU_ADD;
            dec_d.funct7_bit5 = 1'b1;
          end
          2'b10:   dec_d.alu_op = ALU_SLT;
          2'b11:   dec_d.alu_op = ALU_SLTU;
          default: instr_bad = 1'b1;
        endcase
      end

      OPC_LUI: begin
        dec_d.a_sel     = A_ZERO;
        dec_d.b_sel     = B_IMM;
        dec_d.imm       = imm_u;
        dec_d.rd        = rd_f;
        dec_d.alu_op    = ALU_ADD;
        dec_d.reg_write = 1'b1;
      end

      OPC_AUIPC: begin
        dec_d.a_sel     = A_PC;
        dec_d.b_sel     = B_IMM;
        dec_d.imm       = imm_u;
        dec_d.rd        = rd_f;
        dec_d.alu_op    = ALU_ADD;
        dec_d.reg_write = 1'b1;
      end

      // Jumps compute the link address PC+4; the target uses imm
      OPC_JAL: begin
        dec_d.a_sel     = A_PC;
        dec_d.b_sel     = B_FOUR;
        dec_d.imm       = imm_j;
        dec_d.rd        = rd_f;
        dec_d.alu_op    = ALU_ADD;
        dec_d.jump      = 1'b1;
        dec_d.reg_write = 1'b1;
      end

      OPC_JALR: begin
        dec_d.a_sel     = A_PC;
        dec_d.b_sel     = B_FOUR;
        dec_d.imm       = imm_i;
        dec_d.rs1       = rs1_f;
        dec_d.rd        = rd_f;
        dec_d.alu_op    = ALU_ADD;
        dec_d.jump      = 1'b1;
        dec_d.reg_write = 1'b1;
        if (f3 != 3'b000) instr_bad = 1'b1;
      end

      default: instr_bad = 1'b1;
    endcase

    // Illegal instructions become an inert bundle flagged illegal
    if (instr_bad) begin
      dec_d         = '0;
      dec_d.illegal = 1'b1;
      dec_d.funct3  = f3;
      dec_d.pc      = in_pc;
    end

    // Writes to x0 are discarded
    if (dec_d.rd == '0) dec_d.reg_write = 1'b0;
  end

  assign in_ready = !out_valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush &&
                    (ILLEGAL_AS_NOP || !dec_d.illegal);

  // Pipeline register occupancy; flush has priority over a capture
  always_comb begin
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (capture) bundle_q <= dec_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign alu_op      = bundle_q.alu_op;
  assign funct3      = bundle_q.funct3;
  assign funct7_bit5 = bundle_q.funct7_bit5;
  assign a_sel       = bundle_q.a_sel;
  assign b_sel       = bundle_q.b_sel;
  assign imm         = bundle_q.imm;
  assign pc_out      = bundle_q.pc;
  assign rs1         = bundle_q.rs1;
  assign rs2         = bundle_q.rs2;
  assign rd          = bundle_q.rd;
  assign reg_write   = bundle_q.reg_write;
  assign mem_read    = bundle_q.mem_read;
  assign mem_write   = bundle_q.mem_write;
  assign branch      = bundle_q.branch;
  assign jump        = bundle_q.jump;
  assign illegal     = bundle_q.illegal;

endmodule

// File: tb/tb_rv32_alu_decode_stage.sv
// Directed bench for rv32_alu_decode_stage with hand-computed expected bundles.
module tb_rv32_alu_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic [2:0]  funct3;
  logic        funct7_bit5;
  logic [1:0]  a_sel;
  logic [1:0]  b_sel;
  logic [31:0] imm;
  logic [31:0] pc_out;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic        jump;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

  rv32_alu_decode_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_op     (alu_op),
    .funct3     (funct3),
    .funct7_bit5(funct7_bit5),
    .a_sel      (a_sel),
    .b_sel      (b_sel),
    .imm        (imm),
    .pc_out     (pc_out),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .branch     (branch),
    .jump       (jump),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // flags = {reg_write, mem_read, mem_write, branch, jump, illegal}
  task automatic expect_bundle(input string tag, input logic [3:0] alu_e, input logic f7_e,
                               input logic [1:0] as_e, input logic [1:0] bs_e,
                               input logic [31:0] imm_e, input logic [4:0] rd_e,
                               input logic [5:0] flags_e);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".alu_op"}, 32'(alu_op), 32'(alu_e));
    chk({tag, ".f7b5"}, 32'(funct7_bit5), 32'(f7_e));
    chk({tag, ".a_sel"}, 32'(a_sel), 32'(as_e));
    chk({tag, ".b_sel"}, 32'(b_sel), 32'(bs_e));
    chk({tag, ".imm"}, imm, imm_e);
    chk({tag, ".rd"}, 32'(rd), 32'(rd_e));
    chk({tag, ".flags"}, 32'({reg_write, mem_read, mem_write, branch, jump, illegal}),
        32'(flags_e));
  endtask

  // Present one instruction for a single edge with out_ready high
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    in_valid  = 1'b1;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    in_pc     = 32'h0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.alu_op", 32'(alu_op), 32'd0);
    chk("rst.imm", imm, 32'd0);
    chk("rst.rd", 32'(rd), 32'd0);
    chk("rst.reg_write", 32'(reg_write), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.idle_valid", 32'(out_valid), 32'd0);

    // SUB x3,x1,x2
    issue(32'h402081B3, 32'h0000_0010);
    expect_bundle("sub", 4'b0000, 1'b1, 2'b00, 2'b00, 32'h0, 5'd3, 6'b100000);
    chk("sub.rs1", 32'(rs1), 32'd1);
    chk("sub.rs2", 32'(rs2), 32'd2);
    chk("sub.pc", pc_out, 32'h10);
    // ADD x3,x1,x2
    issue(32'h002081B3, 32'h0000_0014);
    expect_bundle("add", 4'b0000, 1'b0, 2'b00, 2'b00, 32'h0, 5'd3, 6'b100000);
    // ADDI x1,x0,-1: bit 30 set but f7b5 forced low
    issue(32'hFFF00093, 32'h0000_0018);
    expect_bundle("addi", 4'b0000, 1'b0, 2'b00, 2'b01, 32'hFFFF_FFFF, 5'd1, 6'b100000);
    // SRAI x5,x6,3
    issue(32'h40335293, 32'h0000_001C);
    expect_bundle("srai", 4'b0101, 1'b1, 2'b00, 2'b01, 32'h3, 5'd5, 6'b100000);
    chk("srai.rs1", 32'(rs1), 32'd6);
    chk("srai.rs2", 32'(rs2), 32'd0);
    // BLT x1,x2,+8
    issue(32'h0020C463, 32'h0000_0020);
    expect_bundle("blt", 4'b0010, 1'b0, 2'b00, 2'b00, 32'h8, 5'd0, 6'b000100);
    // SW x2,8(x1)
    issue(32'h0020A423, 32'h0000_0024);
    expect_bundle("sw", 4'b0000, 1'b0, 2'b00, 2'b01, 32'h8, 5'd0, 6'b001000);
    chk("sw.rs2", 32'(rs2), 32'd2);
    chk("sw.funct3", 32'(funct3), 32'd2);
    // LUI x5,0x12345
    issue(32'h123452B7, 32'h0000_0028);
    expect_bundle("lui", 4'b0000, 1'b0, 2'b10, 2'b01, 32'h1234_5000, 5'd5, 6'b100000);
    // JAL x1,+16
    issue(32'h010000EF, 32'h0000_002C);
    expect_bundle("jal", 4'b0000, 1'b0, 2'b01, 2'b10, 32'h10, 5'd1, 6'b100010);
    // ADD x0,x1,x2: write to x0 suppressed
    issue(32'h00208033, 32'h0000_0030);
    expect_bundle("add_x0", 4'b0000, 1'b0, 2'b00, 2'b00, 32'h0, 5'd0, 6'b000000);
    // SLL with alternate funct7 is illegal
    issue(32'h402091B3, 32'h0000_0034);
    expect_bundle("bad_f7", 4'b0000, 1'b0, 2'b00, 2'b00, 32'h0, 5'd0, 6'b000001);
    // All-zero word is illegal
    issue(32'h00000000, 32'h0000_0038);
    expect_bundle("zero", 4'b0000, 1'b0, 2'b00, 2'b00, 32'h0, 5'd0, 6'b000001);
    chk("zero.pc", pc_out, 32'h38);
    tick();
    chk("drain.valid", 32'(out_valid), 32'd0);

    // Backpressure: three instructions, two stalled cycles
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h002081B3;
    in_pc     = 32'h100;
    tick();
    chk("bp.a_valid", 32'(out_valid), 32'd1);
    chk("bp.a_rd", 32'(rd), 32'd3);
    chk("bp.in_ready0", 32'(in_ready), 32'd0);
    in_instr = 32'hFFF00093;
    in_pc    = 32'h104;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bp.stall_valid", 32'(out_valid), 32'd1);
      chk("bp.stall_rd", 32'(rd), 32'd3);
      chk("bp.stall_pc", pc_out, 32'h100);
      chk("bp.stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.in_ready1", 32'(in_ready), 32'd1);
    tick();
    chk("bp.b_valid", 32'(out_valid), 32'd1);
    chk("bp.b_rd", 32'(rd), 32'd1);
    chk("bp.b_pc", pc_out, 32'h104);
    in_instr = 32'h40335293;
    in_pc    = 32'h108;
    tick();
    chk("bp.c_valid", 32'(out_valid), 32'd1);
    chk("bp.c_rd", 32'(rd), 32'd5);
    chk("bp.c_pc", pc_out, 32'h108);
    in_valid = 1'b0;
    tick();
    chk("bp.empty", 32'(out_valid), 32'd0);
    chk("bp.last_pc", pc_out, 32'h108);

    // Flush with a held bundle and an incoming instruction
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h002081B3;
    in_pc     = 32'h200;
    tick();
    chk("fl.held", 32'(out_valid), 32'd1);
    flush    = 1'b1;
    in_instr = 32'hFFF00093;
    in_pc    = 32'h204;
    tick();
    chk("fl.cleared", 32'(out_valid), 32'd0);
    chk("fl.not_captured", pc_out, 32'h200);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("fl.dropped", 32'(out_valid), 32'd0);

    // Reset asserted mid-burst clears outputs at once
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h002081B3;
    in_pc     = 32'h300;
    tick();
    chk("mr.valid", 32'(out_valid), 32'd1);
    in_instr = 32'h40335293;
    in_pc    = 32'h304;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr.out_valid", 32'(out_valid), 32'd0);
    chk("mr.rd", 32'(rd), 32'd0);
    chk("mr.reg_write", 32'(reg_write), 32'd0);
    chk("mr.pc", pc_out, 32'd0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr.after_valid", 32'(out_valid), 32'd0);
    chk("mr.after_alu", 32'(alu_op), 32'd0);
    chk("mr.in_ready", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
